fdiv_wb_track: RTL and testbench
================================

Name: fdiv_wb_track

Overview:
- Downstream companion of the pipelined Newton divider. It shadows the divider's three execute stages (e1/e2/e3) with a {valid, destination} chain.
- It captures the divider result `s` into a write-back (W) register and drives the FP register-file write port.
- It produces operand-forwarding selects and a dependency stall for the instruction in ID.
- It accumulates sticky result-class flags.

Parameters:
- AW, 5, FP register address width
- DW, 32, result data width

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- ena  in  1  pipeline advance enable; the same signal that drives the divider's ena (top level ties it to ~div stall)
- id_fdiv  in  1  ID holds an fdiv to issue this cycle
- id_fd  in  AW  destination of the ID fdiv
- id_fs  in  AW  ID source register fs
- id_ft  in  AW  ID source register ft
- id_use_fs  in  1  ID instruction reads fs
- id_use_ft  in  1  ID instruction reads ft
- s  in  DW  divider result, valid for the instruction in e3
- flag_clr  in  1  clear sticky flags
- wb_we  out  1  register-file write strobe (one-cycle pulse)
- wb_addr  out  AW  write address
- wb_data  out  DW  write data
- fwd_fs  out  2  fs source select: 0 = regfile, 1 = wb_data, 2 = s
- fwd_ft  out  2  ft source select, same encoding as fwd_fs
- dep_stall  out  1  ID must hold; bubble inserted
- in_flight  out  1  any valid div in e1, e2, e3 or W
- flags  out  3  sticky {nan, inf, zero} of written results

Behaviour:
- Reset (clrn=0, async): all valid bits, wb_we, wb_addr, wb_data and flags are 0. The fwd outputs therefore read 0 and dep_stall reads 0. Reset mid-division discards all in-flight entries; no write occurs after reset is released.
- Chain registers: e1v/e1d, e2v/e2d, e3v/e3d, wv.
- On posedge with ena=1:
  - e1v <= id_fdiv & ~dep_stall; e1d <= id_fd
  - e2 <= e1; e3 <= e2
  - wv <= e3v; wb_we <= e3v
  - when e3v=1: wb_addr <= e3d and wb_data <= s; otherwise wb_addr and wb_data hold
- On posedge with ena=0:
  - every chain register holds, including wv
  - wb_we <= 0, so the write is never repeated during a divider stall
- Latency: a div issued at ID edge N writes at edge N+4, provided ena=1 throughout. Each ena=0 cycle adds one cycle.
- Dependency stall (combinational):
  - dep_stall = (id_use_fs & hit(id_fs)) | (id_use_ft & hit(id_ft))
  - hit(r) = (e1v & e1d==r) | (e2v & e2d==r)
  - A dependency on e1 or e2 stalls because that result is not yet produced.
  - dep_stall does not freeze the chain. It only zeroes the e1 insert; the ID stage holds its instruction externally.
- Forwarding (combinational, per source fs/ft, gated by id_use_*):
  - select 2 if e3v & e3d==r
  - else select 1 if wv & wb_addr==r
  - else select 0
  - e3 has priority over W, so the youngest producer wins.
- Simultaneous events:
  - an id_fdiv arriving with dep_stall=1 inserts a bubble
  - when issue and write-back happen on the same edge, both proceed
- Flags:
  - the class of s is computed at the e3->W capture
  - nan = exp==FF & frac!=0; inf = exp==FF & frac==0; zero = exp==0 & frac==0
  - on an edge where ena & e3v, flags <= (flag_clr ? 0 : flags) | class
  - set wins over a same-cycle clear
  - otherwise flag_clr=1 clears the flags
- in_flight = e1v | e2v | e3v | wv
- No WAW check is needed: execution is strictly in order.

Test Plan:
- Basic latency: ena=1; issue fdiv fd=3 at edge 0, with s=0x3F800000 while e3v -> wb_we=1 for exactly one cycle after edge 4, wb_addr=3, wb_data=0x3F800000; flags stay 000.
- Divider stall: issue fd=7, then hold ena=0 for 10 cycles while the entry is in e2 -> no advance and wb_we=0 throughout; the write occurs 14 cycles after issue; in_flight=1 until the W entry ages out.
- Dependency: fd=5 in e1, ID reads fs=5 with id_use_fs=1 and id_fdiv=1 -> dep_stall=1 and e1v becomes 0 at the next edge. When fd=5 reaches e3 -> dep_stall=0 and fwd_fs=2.
- Forward priority: e3 holds fd=9 and W holds fd=9; ID ft=9 with id_use_ft=1 -> fwd_ft=2. With id_use_ft=0 -> fwd_ft=0. With W-only match -> fwd_ft=1.
- Flags: write s=0x7FC00000, then s=0x7F800000 -> flags=110. Assert flag_clr on the same edge as a write of s=0x00000000 -> flags=001.
- Reset mid-flight: entries in e1 and e3, pulse clrn=0 -> all outputs 0 immediately; no wb_we after release.

Source files
------------

// File: rtl/fdiv_wb_track_if.sv
// Bundle between the divider write-back tracker and its surroundings (ID stage,
// divider datapath, FP register file).
//   master : drives ena, the ID-stage fdiv/source info, divider result s, flag_clr
//   slave  : the tracker; drives the regfile write port, forward selects,
//            dependency stall, in_flight and the sticky flags
interface fdiv_wb_track_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          ena;
  logic          id_fdiv;
  logic [AW-1:0] id_fd;
  logic [AW-1:0] id_fs;
  logic [AW-1:0] id_ft;
  logic          id_use_fs;
  logic          id_use_ft;
  logic [DW-1:0] s;
  logic          flag_clr;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [1:0]    fwd_fs;
  logic [1:0]    fwd_ft;
  logic          dep_stall;
  logic          in_flight;
  logic [2:0]    flags;

  modport master (
    output ena, id_fdiv, id_fd, id_fs, id_ft, id_use_fs, id_use_ft, s, flag_clr,
    input  wb_we, wb_addr, wb_data, fwd_fs, fwd_ft, dep_stall, in_flight, flags
  );

  modport slave (
    input  ena, id_fdiv, id_fd, id_fs, id_ft, id_use_fs, id_use_ft, s, flag_clr,
    output wb_we, wb_addr, wb_data, fwd_fs, fwd_ft, dep_stall, in_flight, flags
  );
endinterface

// File: rtl/fdiv_wb_track.sv
// Write-back tracker for the pipelined Newton divider. Shadows the divider's
// e1/e2/e3 stages with {valid, destination}, captures the e3 result into a W
// register that drives the FP regfile write port, and produces forwarding
// selects plus a dependency stall for the instruction in ID. Also keeps sticky
// {nan, inf, zero} flags of written results.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : slave side of fdiv_wb_track_if (see interface for signal list)
module fdiv_wb_track #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input logic             clk,
  input logic             clrn,
  fdiv_wb_track_if.slave  bus
);

  logic          e1v_q, e1v_d, e2v_q, e2v_d, e3v_q, e3v_d, wv_q, wv_d;
  logic [AW-1:0] e1d_q, e1d_d, e2d_q, e2d_d, e3d_q, e3d_d;
  logic          wb_we_q, wb_we_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [2:0]    flags_q, flags_d;

  logic          dep_stall;
  logic          hit_fs, hit_ft;
  logic [7:0]    s_exp;
  logic [22:0]   s_frac;
  logic [2:0]    s_class;

  // Result class of s, IEEE single layout.
  assign s_exp   = bus.s[30:23];
  assign s_frac  = bus.s[22:0];
  assign s_class = {(s_exp == 8'hff) && (s_frac != '0),
                    (s_exp == 8'hff) && (s_frac == '0),
                    (s_exp == 8'h00) && (s_frac == '0)};

  // Producers in e1/e2 have no result yet, so a reader must wait.
  always_comb begin
    hit_fs    = (e1v_q && (e1d_q == bus.id_fs)) || (e2v_q && (e2d_q == bus.id_fs));
    hit_ft    = (e1v_q && (e1d_q == bus.id_ft)) || (e2v_q && (e2d_q == bus.id_ft));
    dep_stall = (bus.id_use_fs && hit_fs) || (bus.id_use_ft && hit_ft);
  end

  // e3 is checked before W so the youngest producer wins.
  always_comb begin
    bus.fwd_fs = 2'd0;
    if (bus.id_use_fs) begin
      if (e3v_q && (e3d_q == bus.id_fs))           bus.fwd_fs = 2'd2;
      else if (wv_q && (wb_addr_q == bus.id_fs))   bus.fwd_fs = 2'd1;
    end
    bus.fwd_ft = 2'd0;
    if (bus.id_use_ft) begin
      if (e3v_q && (e3d_q == bus.id_ft))           bus.fwd_ft = 2'd2;
      else if (wv_q && (wb_addr_q == bus.id_ft))   bus.fwd_ft = 2'd1;
    end
  end

  always_comb begin
    e1v_d     = e1v_q;
    e1d_d     = e1d_q;
    e2v_d     = e2v_q;
    e2d_d     = e2d_q;
    e3v_d     = e3v_q;
    e3d_d     = e3d_q;
    wv_d      = wv_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    // Strobe drops while stalled so a write is never repeated.
    wb_we_d   = 1'b0;
    flags_d   = flags_q;

    if (bus.ena) begin
      e1v_d   = bus.id_fdiv && !dep_stall;
      e1d_d   = bus.id_fd;
      e2v_d   = e1v_q;
      e2d_d   = e1d_q;
      e3v_d   = e2v_q;
      e3d_d   = e2d_q;
      wv_d    = e3v_q;
      wb_we_d = e3v_q;
      if (e3v_q) begin
        wb_addr_d = e3d_q;
        wb_data_d = bus.s;
      end
    end

    // A new class bit survives a same-cycle clear.
    if (bus.ena && e3v_q) begin
      flags_d = (bus.flag_clr ? 3'b000 : flags_q) | s_class;
    end else if (bus.flag_clr) begin
      flags_d = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1v_q     <= 1'b0;
      e1d_q     <= '0;
      e2v_q     <= 1'b0;
      e2d_q     <= '0;
      e3v_q     <= 1'b0;
      e3d_q     <= '0;
      wv_q      <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flags_q   <= 3'b000;
    end else begin
      e1v_q     <= e1v_d;
      e1d_q     <= e1d_d;
      e2v_q     <= e2v_d;
      e2d_q     <= e2d_d;
      e3v_q     <= e3v_d;
      e3d_q     <= e3d_d;
      wv_q      <= wv_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.wb_we     = wb_we_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.dep_stall = dep_stall;
  assign bus.in_flight = e1v_q || e2v_q || e3v_q || wv_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fdiv_wb_track.sv
module tb_fdiv_wb_track;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  fdiv_wb_track_if #(.AW(5), .DW(32)) bus ();

  fdiv_wb_track #(.AW(5), .DW(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       adv;     // one enabled edge issuing adv_fd before the lookup
    logic [4:0] adv_fd;
    logic       use_fs;
    logic [4:0] fs;
    logic       use_ft;
    logic [4:0] ft;
    logic [1:0] e_fs;
    logic [1:0] e_ft;
    logic       e_dep;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.ena = 1'b1; bus.id_fdiv = 1'b0; bus.id_fd = '0; bus.id_fs = '0; bus.id_ft = '0;
    bus.id_use_fs = 1'b0; bus.id_use_ft = 1'b0; bus.s = 32'hdeadbeef; bus.flag_clr = 1'b0;

    // Forward table; first four start from e3=9, W=9, e1/e2 empty.
    vecs[0] = '{1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 2'd0, 2'd2, 1'b0};
    vecs[1] = '{1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 5'd9, 2'd0, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd3, 2'd2, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd9, 2'd0, 2'd2, 1'b0};
    // After advance: e1=4, W=9, e3 empty.
    vecs[4] = '{1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd9, 2'd0, 2'd1, 1'b0};
    vecs[5] = '{1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1};
    vecs[6] = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd4, 2'd1, 2'd0, 1'b1};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 5'd4, 2'd0, 2'd0, 1'b0};

    // Reset state
    #2;
    chk("rst_we", 32'(bus.wb_we), 0);
    chk("rst_addr", 32'(bus.wb_addr), 0);
    chk("rst_data", bus.wb_data, 0);
    chk("rst_inflight", 32'(bus.in_flight), 0);
    chk("rst_flags", 32'(bus.flags), 0);
    #10 clrn = 1'b1;
    tick();

    // Basic latency: write strobe one cycle, after the 4th edge
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd3;
    tick();
    bus.id_fdiv = 1'b0;
    chk("lat_we1", 32'(bus.wb_we), 0);
    chk("lat_inflight", 32'(bus.in_flight), 1);
    tick();
    chk("lat_we2", 32'(bus.wb_we), 0);
    tick();
    chk("lat_we3", 32'(bus.wb_we), 0);
    bus.s = 32'h3f800000;
    tick();
    chk("lat_we4", 32'(bus.wb_we), 1);
    chk("lat_addr", 32'(bus.wb_addr), 3);
    chk("lat_data", bus.wb_data, 32'h3f800000);
    bus.s = 32'hdeadbeef;
    tick();
    chk("lat_we5", 32'(bus.wb_we), 0);
    chk("lat_flags", 32'(bus.flags), 0);
    chk("lat_hold_data", bus.wb_data, 32'h3f800000);
    drain(2);

    // Divider stall with the entry in e2
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd7;
    tick();
    bus.id_fdiv = 1'b0;
    tick();
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_we_%0d", i), 32'(bus.wb_we), 0);
      chk($sformatf("stall_inflight_%0d", i), 32'(bus.in_flight), 1);
    end
    bus.ena = 1'b1;
    tick();
    chk("stall_we_e3", 32'(bus.wb_we), 0);
    bus.s = 32'h40000000;
    tick();
    chk("stall_we14", 32'(bus.wb_we), 1);
    chk("stall_addr", 32'(bus.wb_addr), 7);
    chk("stall_data", bus.wb_data, 32'h40000000);
    bus.ena = 1'b0;
    tick();
    chk("stall_we_norepeat", 32'(bus.wb_we), 0);
    chk("stall_w_held", 32'(bus.in_flight), 1);
    bus.ena = 1'b1;
    tick();
    chk("stall_aged_out", 32'(bus.in_flight), 0);
    bus.s = 32'hdeadbeef;
    drain(2);

    // Dependency stall, bubble, then forward from e3 and W
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd5;
    tick();
    bus.id_fd = 5'd6; bus.id_fs = 5'd5; bus.id_use_fs = 1'b1;
    #1;
    chk("dep_e1", 32'(bus.dep_stall), 1);
    tick();
    chk("dep_e2", 32'(bus.dep_stall), 1);
    chk("dep_e2_fwd", 32'(bus.fwd_fs), 0);
    tick();
    chk("dep_e3_clear", 32'(bus.dep_stall), 0);
    chk("dep_e3_fwd", 32'(bus.fwd_fs), 2);
    bus.s = 32'h3f800000;
    tick();
    bus.id_fdiv = 1'b0;
    #1;
    chk("dep_wb_we", 32'(bus.wb_we), 1);
    chk("dep_wb_addr", 32'(bus.wb_addr), 5);
    chk("dep_w_fwd", 32'(bus.fwd_fs), 1);
    chk("dep_w_nostall", 32'(bus.dep_stall), 0);
    tick();
    chk("dep_bubble_nowrite", 32'(bus.wb_we), 0);
    bus.id_use_fs = 1'b0;
    tick();
    bus.s = 32'h40400000;
    tick();
    chk("dep_fd6_we", 32'(bus.wb_we), 1);
    chk("dep_fd6_addr", 32'(bus.wb_addr), 6);
    chk("dep_fd6_data", bus.wb_data, 32'h40400000);
    bus.s = 32'hdeadbeef;
    drain(2);

    // Forward priority table: build e3=9, W=9, then freeze with ena=0
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd9;
    tick();
    tick();
    bus.id_fdiv = 1'b0;
    tick();
    bus.s = 32'h3f800000;
    tick();
    bus.ena = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].adv) begin
        bus.id_use_fs = 1'b0; bus.id_use_ft = 1'b0;
        bus.id_fdiv = 1'b1; bus.id_fd = vecs[i].adv_fd; bus.ena = 1'b1;
        tick();
        bus.id_fdiv = 1'b0; bus.ena = 1'b0;
      end
      bus.id_use_fs = vecs[i].use_fs; bus.id_fs = vecs[i].fs;
      bus.id_use_ft = vecs[i].use_ft; bus.id_ft = vecs[i].ft;
      #1;
      chk($sformatf("vec%0d_fwd_fs", i), 32'(bus.fwd_fs), 32'(vecs[i].e_fs));
      chk($sformatf("vec%0d_fwd_ft", i), 32'(bus.fwd_ft), 32'(vecs[i].e_ft));
      chk($sformatf("vec%0d_dep", i), 32'(bus.dep_stall), 32'(vecs[i].e_dep));
    end
    bus.id_use_fs = 1'b0; bus.id_use_ft = 1'b0; bus.ena = 1'b1;
    drain(5);
    chk("tbl_flags", 32'(bus.flags), 0);

    // Sticky flags
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd1;
    tick();
    bus.id_fd = 5'd2;
    tick();
    bus.id_fdiv = 1'b0;
    tick();
    bus.s = 32'h7fc00000;
    tick();
    chk("flag_nan", 32'(bus.flags), 32'b100);
    bus.s = 32'h7f800000;
    tick();
    chk("flag_nan_inf", 32'(bus.flags), 32'b110);
    chk("flag_inf_data", bus.wb_data, 32'h7f800000);
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd3;
    tick();
    bus.id_fdiv = 1'b0;
    tick();
    tick();
    bus.s = 32'h00000000; bus.flag_clr = 1'b1;
    tick();
    chk("flag_clr_and_zero", 32'(bus.flags), 32'b001);
    tick();
    chk("flag_clr_only", 32'(bus.flags), 0);
    bus.flag_clr = 1'b0;
    drain(2);

    // Reset mid-flight with entries in e1 and e3
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd10;
    tick();
    bus.id_fdiv = 1'b0;
    tick();
    bus.id_fdiv = 1'b1; bus.id_fd = 5'd11;
    tick();
    bus.id_fdiv = 1'b0;
    bus.id_use_fs = 1'b1; bus.id_fs = 5'd11; bus.id_use_ft = 1'b1; bus.id_ft = 5'd10;
    #1;
    chk("pre_rst_dep", 32'(bus.dep_stall), 1);
    chk("pre_rst_fwd_ft", 32'(bus.fwd_ft), 2);
    #1 clrn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.wb_we), 0);
    chk("mid_rst_addr", 32'(bus.wb_addr), 0);
    chk("mid_rst_inflight", 32'(bus.in_flight), 0);
    chk("mid_rst_dep", 32'(bus.dep_stall), 0);
    chk("mid_rst_fwd_ft", 32'(bus.fwd_ft), 0);
    #2 clrn = 1'b1;
    bus.id_use_fs = 1'b0; bus.id_use_ft = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_we_%0d", i), 32'(bus.wb_we), 0);
      chk($sformatf("post_rst_inflight_%0d", i), 32'(bus.in_flight), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
